// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer.
// Holds the FSM state encoding, the error codes and the memory mode values.
package calc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_L,
    RD_B,
    POP_B,
    RD_A,
    POP_A,
    EXEC,
    PUSH_Y,
    WAIT,
    DONE
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  localparam logic MODE_STACK = 1'b0;
  localparam logic MODE_QUEUE = 1'b1;

endpackage

// File: rtl/calc_wait_timer.sv
// Loadable down-counter that paces the memory access latency.
// Loading primes it for MEM_LAT cycles; o_expired flags the final cycle.
module calc_wait_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(MEM_LAT - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/calc_op_sequencer.sv
// Command sequencer: pushes literals or runs pop-B/pop-A/ALU/push-result ops
// against an external stack/queue memory, with occupancy guards and a done pulse.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_is_op,
  input  logic [2:0]                 cmd_op,
  input  logic [15:0]                cmd_data,
  input  logic                       cmd_mode,
  output logic                       mem_mode,
  output logic                       mem_push,
  output logic                       mem_pop,
  output logic [31:0]                mem_din,
  input  logic [31:0]                stack_head,
  input  logic [31:0]                queue_head,
  input  logic                       mem_empty,
  input  logic                       mem_full,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [2:0]                 alu_op,
  input  logic [31:0]                alu_y,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       done,
  output logic [1:0]                 err,
  output logic                       busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        r_state;
  state_e        r_ret;
  state_e        w_next;
  logic [CW-1:0] r_count;
  logic [1:0]    r_err;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [2:0]    r_op;
  logic          r_mode;
  logic [15:0]   r_data;

  logic        w_accept;
  logic        w_full;
  logic        w_short;
  logic        w_expired;
  logic        w_enter_wait;
  logic [31:0] w_head;

  assign w_accept     = cmd_valid && (r_state == IDLE);
  assign w_full       = (r_count == DEPTH_C) || mem_full;
  assign w_short      = (r_count < CW'(2)) || mem_empty;
  assign w_head       = (r_mode == MODE_QUEUE) ? queue_head : stack_head;
  assign w_enter_wait = r_state inside {PUSH_L, POP_B, POP_A, PUSH_Y};

  calc_wait_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_enter_wait),
    .i_dec    (r_state == WAIT),
    .o_expired(w_expired)
  );

  // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_is_op) w_next = w_short ? DONE : RD_B;
          else           w_next = w_full  ? DONE : PUSH_L;
        end
      end
      PUSH_L, POP_B, POP_A, PUSH_Y: w_next = WAIT;
      RD_B:    w_next = POP_B;
      RD_A:    w_next = POP_A;
      EXEC:    w_next = PUSH_Y;
      WAIT:    if (w_expired) w_next = r_ret;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Each memory access records where WAIT should resume once latency has elapsed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ret   <= IDLE;
    end else begin
      r_state <= w_next;
      case (r_state)
        PUSH_L, PUSH_Y: r_ret <= DONE;
        POP_B:          r_ret <= RD_A;
        POP_A:          r_ret <= EXEC;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_err   <= ERR_NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_mode  <= MODE_STACK;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= cmd_mode;
        r_op   <= cmd_op;
        r_data <= cmd_data;
        if (cmd_is_op) r_err <= w_short ? ERR_UNDER : ERR_NONE;
        else           r_err <= w_full  ? ERR_OVER  : ERR_NONE;
      end
      if (r_state == RD_B) r_b <= w_head;
      if (r_state == RD_A) r_a <= w_head;
      case (r_state)
        PUSH_L, PUSH_Y: r_count <= r_count + CW'(1);
        POP_B, POP_A:   r_count <= r_count - CW'(1);
        default:        ;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign mem_push  = (r_state == PUSH_L) || (r_state == PUSH_Y);
  assign mem_pop   = (r_state == POP_B) || (r_state == POP_A);
  assign mem_din   = (r_state == PUSH_L) ? {16'b0, r_data} :
                     (r_state == PUSH_Y) ? alu_y : 32'b0;
  assign mem_mode  = r_mode;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: a queue-based stack/queue memory,
// a bench ALU, and a command-level reference model driving randomized and directed checks.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 1;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_is_op = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [15:0]   cmd_data = '0;
  logic          cmd_mode = 1'b0;
  logic          mem_mode;
  logic          mem_push;
  logic          mem_pop;
  logic [31:0]   mem_din;
  logic [31:0]   stack_head = '0;
  logic [31:0]   queue_head = '0;
  logic          mem_empty = 1'b1;
  logic          mem_full = 1'b0;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [2:0]    alu_op;
  logic [31:0]   alu_y;
  logic [CW-1:0] count;
  logic          done;
  logic [1:0]    err;
  logic          busy;

  calc_op_sequencer #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_op(cmd_is_op), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_mode(cmd_mode),
    .mem_mode(mem_mode), .mem_push(mem_push), .mem_pop(mem_pop), .mem_din(mem_din),
    .stack_head(stack_head), .queue_head(queue_head), .mem_empty(mem_empty),
    .mem_full(mem_full), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .count(count), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench ALU: opcode 1 is an absolute difference so results stay small and positive.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return (a > b) ? a - b : b - a;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a * b;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  assign alu_y = alu_ref(alu_op, alu_a, alu_b);

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mon_push = 0;
  int          mon_pop  = 0;
  int          mon_done = 0;
  int          mon_both = 0;
  logic [31:0] mon_din  = '0;
  logic        m_push = 1'b0;
  logic        m_pop = 1'b0;
  logic        m_mode = 1'b0;
  logic [31:0] m_din = '0;
  logic [31:0] mem_q[$];

  always @(negedge clk) begin
    m_push = mem_push;
    m_pop  = mem_pop;
    m_mode = mem_mode;
    m_din  = mem_din;
    if (mem_push) begin
      mon_push++;
      mon_din = mem_din;
    end
    if (mem_pop) mon_pop++;
    if (done) mon_done++;
    if (mem_push && mem_pop) mon_both++;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q.delete();
      m_push = 1'b0;
      m_pop  = 1'b0;
      stack_head <= '0;
      queue_head <= '0;
      mem_empty  <= 1'b1;
      mem_full   <= 1'b0;
    end else begin
      if (m_push && mem_q.size() < DEPTH) mem_q.push_back(m_din);
      else if (m_pop && mem_q.size() > 0) begin
        if (m_mode) void'(mem_q.pop_front());
        else        void'(mem_q.pop_back());
      end
      m_push = 1'b0;
      m_pop  = 1'b0;
      stack_head <= (mem_q.size() > 0) ? mem_q[$] : 32'h0;
      queue_head <= (mem_q.size() > 0) ? mem_q[0] : 32'h0;
      mem_empty  <= (mem_q.size() == 0);
      mem_full   <= (mem_q.size() >= DEPTH);
    end
  end

  // Reference model: a plain queue holding what the memory should contain.
  logic [31:0] mq[$];
  int          exp_lat;
  int          exp_pushes;
  int          exp_pops;
  logic [1:0]  exp_err;
  logic [31:0] exp_a = '0;
  logic [31:0] exp_b = '0;
  logic [31:0] exp_din;

  task automatic model_cmd(input bit is_op, input logic [2:0] op, input logic [15:0] data,
                           input bit mode);
    exp_pushes = 0;
    exp_pops   = 0;
    if (!is_op) begin
      if (mq.size() == DEPTH) begin
        exp_err = ERR_OVER;
        exp_lat = 1;
      end else begin
        exp_din = {16'h0, data};
        mq.push_back(exp_din);
        exp_err    = ERR_NONE;
        exp_lat    = 2 + MEM_LAT;
        exp_pushes = 1;
      end
    end else if (mq.size() < 2) begin
      exp_err = ERR_UNDER;
      exp_lat = 1;
    end else begin
      exp_b   = mode ? mq.pop_front() : mq.pop_back();
      exp_a   = mode ? mq.pop_front() : mq.pop_back();
      exp_din = alu_ref(op, exp_a, exp_b);
      mq.push_back(exp_din);
      exp_err    = ERR_NONE;
      exp_lat    = 7 + 3 * MEM_LAT;
      exp_pushes = 1;
      exp_pops   = 2;
    end
  endtask

  int            obs_lat;
  int            obs_pushes;
  int            obs_pops;
  logic [1:0]    obs_err;
  logic [CW-1:0] obs_count;
  logic [31:0]   obs_a;
  logic [31:0]   obs_b;
  logic [31:0]   obs_din;

  // Drives one command, measures accept-to-done latency and records outputs at done.
  task automatic exec_cmd(input bit is_op, input logic [2:0] op, input logic [15:0] data,
                          input bit mode);
    int p0, q0, w;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_is_op = is_op;
    cmd_op    = op;
    cmd_data  = data;
    cmd_mode  = mode;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    p0 = mon_push;
    q0 = mon_pop;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 16'($urandom);
    obs_lat = 1;
    while (!done && obs_lat < 40) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_err   = err;
    obs_count = count;
    obs_a     = alu_a;
    obs_b     = alu_b;
    #1;
    obs_pushes = mon_push - p0;
    obs_pops   = mon_pop - q0;
    obs_din    = mon_din;
  endtask

  task automatic do_reset;
    cmd_valid = 1'b0;
    rst = 1'b0;
    mq.delete();
    exp_a = '0;
    exp_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++;
    if ({count, err, alu_a, alu_b, alu_op, mem_mode, done, busy, mem_push, mem_pop, mem_din}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: count=%0d err=%0d a=%0h b=%0h op=%0d mode=%0b done=%0b busy=%0b required all zero",
               count, err, alu_a, alu_b, alu_op, mem_mode, done, busy);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b required 1", cmd_ready);
    end
  endtask

  task automatic test_stack_add;
    do_reset();
    model_cmd(0, 3'd0, 16'd5, MODE_STACK);
    exec_cmd(0, 3'd0, 16'd5, MODE_STACK);
    n_checks++;
    if (obs_lat !== 3 || obs_err !== ERR_NONE || obs_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL push5: lat=%0d err=%0d count=%0d required 3/0/1", obs_lat, obs_err, obs_count);
    end
    model_cmd(0, 3'd0, 16'd7, MODE_STACK);
    exec_cmd(0, 3'd0, 16'd7, MODE_STACK);
    n_checks++;
    if (obs_lat !== 3 || obs_err !== ERR_NONE || obs_count !== CW'(2)) begin
      n_fail++;
      $display("FAIL push7: lat=%0d err=%0d count=%0d required 3/0/2", obs_lat, obs_err, obs_count);
    end
    model_cmd(1, 3'd0, 16'd0, MODE_STACK);
    exec_cmd(1, 3'd0, 16'd0, MODE_STACK);
    n_checks++;
    if (obs_lat !== 10 || obs_err !== ERR_NONE || obs_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL add_timing: lat=%0d err=%0d count=%0d required 10/0/1", obs_lat, obs_err, obs_count);
    end
    n_checks++;
    if (obs_b !== 32'd7 || obs_a !== 32'd5 || obs_din !== 32'd12 || obs_pops !== 2) begin
      n_fail++;
      $display("FAIL add_data: b=%0d a=%0d din=%0d pops=%0d required 7/5/12/2",
               obs_b, obs_a, obs_din, obs_pops);
    end
  endtask

  task automatic test_queue_sub;
    do_reset();
    exec_cmd(0, 3'd0, 16'd9, MODE_QUEUE);
    exec_cmd(0, 3'd0, 16'd4, MODE_QUEUE);
    exec_cmd(1, 3'd1, 16'd0, MODE_QUEUE);
    n_checks++;
    if (obs_b !== 32'd9 || obs_a !== 32'd4 || obs_din !== 32'd5 || obs_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL queue_sub: b=%0d a=%0d din=%0d count=%0d required 9/4/5/1",
               obs_b, obs_a, obs_din, obs_count);
    end
  endtask

  task automatic test_underflow;
    do_reset();
    exec_cmd(0, 3'd0, 16'd3, MODE_STACK);
    exec_cmd(1, 3'd0, 16'd0, MODE_STACK);
    n_checks++;
    if (obs_lat !== 1 || obs_err !== ERR_UNDER || obs_pops !== 0 || obs_count !== CW'(1)) begin
      n_fail++;
      $display("FAIL underflow: lat=%0d err=%0d pops=%0d count=%0d required 1/1/0/1",
               obs_lat, obs_err, obs_pops, obs_count);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 4; i++) exec_cmd(0, 3'd0, 16'(10 + i), MODE_STACK);
    exec_cmd(0, 3'd0, 16'd99, MODE_STACK);
    n_checks++;
    if (obs_lat !== 1 || obs_err !== ERR_OVER || obs_pushes !== 0 || obs_count !== CW'(4)) begin
      n_fail++;
      $display("FAIL overflow: lat=%0d err=%0d pushes=%0d count=%0d required 1/2/0/4",
               obs_lat, obs_err, obs_pushes, obs_count);
    end
    exec_cmd(1, 3'd0, 16'd0, MODE_STACK);
    n_checks++;
    if (obs_err !== ERR_NONE || obs_count !== CW'(3) || obs_din !== 32'd25) begin
      n_fail++;
      $display("FAIL op_when_full: err=%0d count=%0d din=%0d required 0/3/25",
               obs_err, obs_count, obs_din);
    end
  endtask

  task automatic test_back_to_back;
    int p0, q0, d0, b0, ep, eq, acc, bad, w;
    bit prev_ready;
    do_reset();
    p0 = mon_push; q0 = mon_pop; d0 = mon_done; b0 = mon_both;
    ep = 0; eq = 0; acc = 0; bad = 0; prev_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_is_op = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 16'($urandom);
    cmd_mode  = 1'($urandom);
    for (int c = 0; c < 80; c++) begin
      if (cmd_ready !== !busy) bad++;
      if (prev_ready && !busy) bad++;
      prev_ready = cmd_ready;
      if (cmd_ready) begin
        model_cmd(cmd_is_op, cmd_op, cmd_data, cmd_mode);
        ep += exp_pushes;
        eq += exp_pops;
        acc++;
        @(posedge clk);
        #1;
        cmd_is_op = !cmd_is_op;
        cmd_op    = 3'($urandom);
        cmd_data  = 16'($urandom);
        cmd_mode  = 1'($urandom);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    w = 0;
    while (busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    #1;
    n_checks++;
    if (bad !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handshake: violations=%0d busy=%0b required 0/0", bad, busy);
    end
    n_checks++;
    if (mon_push - p0 !== ep || mon_pop - q0 !== eq || mon_both - b0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: pushes=%0d pops=%0d overlap=%0d required %0d/%0d/0",
               mon_push - p0, mon_pop - q0, mon_both - b0, ep, eq);
    end
    n_checks++;
    if (mon_done - d0 !== acc || acc < 5 || count !== CW'(mq.size())) begin
      n_fail++;
      $display("FAIL b2b_done: dones=%0d accepts=%0d count=%0d required dones=accepts, count=%0d",
               mon_done - d0, acc, count, mq.size());
    end
  endtask

  task automatic test_reset_mid;
    int d0, np;
    do_reset();
    exec_cmd(0, 3'd0, 16'd1, MODE_STACK);
    exec_cmd(0, 3'd0, 16'd2, MODE_STACK);
    d0 = mon_done;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_is_op = 1'b1;
    cmd_op    = 3'd0;
    cmd_mode  = MODE_STACK;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    np = 0;
    for (int w = 0; w < 15; w++) begin
      if (mem_pop) np++;
      if (np == 2) break;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (np !== 2 || {count, busy, mem_pop, mem_push, done, err, alu_a, alu_b, alu_op, mem_mode}
        !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: pops_seen=%0d count=%0d busy=%0b pop=%0b a=%0h b=%0h required 2 then all zero",
               np, count, busy, mem_pop, alu_a, alu_b);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mq.delete();
    exp_a = '0;
    exp_b = '0;
    n_checks++;
    if (mon_done !== d0) begin
      n_fail++;
      $display("FAIL mid_reset_done: got %0d done pulses required 0", mon_done - d0);
    end
    exec_cmd(0, 3'd0, 16'd1, MODE_STACK);
    n_checks++;
    if (obs_count !== CW'(1) || obs_err !== ERR_NONE || obs_lat !== 3) begin
      n_fail++;
      $display("FAIL after_reset_push: count=%0d err=%0d lat=%0d required 1/0/3",
               obs_count, obs_err, obs_lat);
    end
  endtask

  task automatic test_random;
    bit          is_op;
    bit          mode;
    logic [2:0]  op;
    logic [15:0] data;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      is_op = (i < 20) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      mode  = 1'($urandom);
      op    = 3'($urandom);
      data  = 16'($urandom);
      model_cmd(is_op, op, data, mode);
      exec_cmd(is_op, op, data, mode);
      n_checks++;
      if (obs_lat !== exp_lat || obs_err !== exp_err || obs_count !== CW'(mq.size())) begin
        n_fail++;
        $display("FAIL rand_%0d_status: lat=%0d err=%0d count=%0d required %0d/%0d/%0d",
                 i, obs_lat, obs_err, obs_count, exp_lat, exp_err, mq.size());
      end
      n_checks++;
      if (obs_a !== exp_a || obs_b !== exp_b || obs_pushes !== exp_pushes
          || obs_pops !== exp_pops || (exp_pushes == 1 && obs_din !== exp_din)) begin
        n_fail++;
        $display("FAIL rand_%0d_data: a=%0h b=%0h din=%0h push=%0d pop=%0d required %0h/%0h/%0h/%0d/%0d",
                 i, obs_a, obs_b, obs_din, obs_pushes, obs_pops, exp_a, exp_b, exp_din,
                 exp_pushes, exp_pops);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stack_add();
    test_queue_sub();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
